// File: rtl/sync_fifo_defs.sv
// Shared constants for the single-clock FIFO: default geometry and the
// read-port mode selectors.
package sync_fifo_defs;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_SIZE_DEF  = 3;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: depth x data_width register file, synchronous write and
// asynchronous read. Deliberately not reset.
module sync_fifo_mem #(
  parameter int unsigned data_width = 8,
  parameter int unsigned addr_size  = 3
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [addr_size-1:0]  i_waddr,
  input  logic [data_width-1:0] i_wdata,
  input  logic [addr_size-1:0]  i_raddr,
  output logic [data_width-1:0] o_rdata
);

  logic [data_width-1:0] r_mem [(1 << addr_size)];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with optional first-word-fall-through read port,
// occupancy count, almost-full/empty thresholds and sticky error flags.
module sync_fifo
  import sync_fifo_defs::*;
#(
  parameter int unsigned data_width    = DATA_WIDTH_DEF,
  parameter int unsigned addr_size     = ADDR_SIZE_DEF,
  parameter int unsigned fwft          = FIFO_STD,
  parameter int unsigned afull_thresh  = (1 << addr_size) - 1,
  parameter int unsigned aempty_thresh = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  winc,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rinc,
  output logic [data_width-1:0] rd_data,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  wr_almost_full,
  output logic                  rd_almost_empty,
  output logic [addr_size:0]    fill_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [addr_size:0] DEPTH   = {1'b1, {addr_size{1'b0}}};
  localparam logic [addr_size:0] AFULL   = (addr_size + 1)'(afull_thresh);
  localparam logic [addr_size:0] AEMPTY  = (addr_size + 1)'(aempty_thresh);

  logic [addr_size:0]    r_wptr;
  logic [addr_size:0]    r_rptr;
  logic [addr_size:0]    r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_clear;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [data_width-1:0] w_mem_rdata;

  // Status decodes only from the registered count, never from winc/rinc.
  assign w_full  = (r_count == DEPTH);
  assign w_empty = (r_count == '0);
  assign w_clear = !rst_n || flush;

  // Acceptance is gated on pre-edge status, so full+both pops and empty+both pushes.
  assign w_wr_acc = winc && !w_full;
  assign w_rd_acc = rinc && !w_empty;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (winc && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rinc && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  sync_fifo_mem #(
    .data_width (data_width),
    .addr_size  (addr_size)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc && !w_clear),
    .i_waddr (r_wptr[addr_size-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rptr[addr_size-1:0]),
    .o_rdata (w_mem_rdata)
  );

  generate
    if (fwft == FIFO_FWFT) begin : g_fwft
      assign rd_data = w_mem_rdata;
    end else begin : g_std
      logic [data_width-1:0] r_rd_data;

      always_ff @(posedge clk) begin
        if (w_clear) begin
          r_rd_data <= '0;
        end else if (w_rd_acc) begin
          r_rd_data <= w_mem_rdata;
        end
      end

      assign rd_data = r_rd_data;
    end
  endgenerate

  assign wfull           = w_full;
  assign rempty          = w_empty;
  assign wr_almost_full  = (r_count >= AFULL);
  assign rd_almost_empty = (r_count <= AEMPTY);
  assign fill_level      = r_count;
  assign overflow        = r_overflow;
  assign underflow       = r_underflow;

  // Pointer distance modulo 2*depth must always equal the occupancy counter.
  assert property (@(posedge clk) disable iff (!rst_n) (r_wptr - r_rptr) == r_count);

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-mode and an FWFT-mode instance
// share one stimulus stream; each scenario task checks its own results.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] wr_data = '0;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_wfull, s_rempty, s_afull, s_aempty, s_ovf, s_unf;
  logic       f_wfull, f_rempty, f_afull, f_aempty, f_ovf, f_unf;
  logic [3:0] s_fill, f_fill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo #(.data_width(8), .addr_size(3), .fwft(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wr_data(wr_data),
    .rinc(rinc), .rd_data(s_rd_data), .wfull(s_wfull), .rempty(s_rempty),
    .wr_almost_full(s_afull), .rd_almost_empty(s_aempty), .fill_level(s_fill),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo #(.data_width(8), .addr_size(3), .fwft(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wr_data(wr_data),
    .rinc(rinc), .rd_data(f_rd_data), .wfull(f_wfull), .rempty(f_rempty),
    .wr_almost_full(f_afull), .rd_almost_empty(f_aempty), .fill_level(f_fill),
    .overflow(f_ovf), .underflow(f_unf)
  );

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_flush();
    winc = 1'b0; rinc = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    winc = 1'b1; rinc = 1'b0; wr_data = d;
    cycle();
    winc = 1'b0;
  endtask

  task automatic pop();
    winc = 1'b0; rinc = 1'b1;
    cycle();
    rinc = 1'b0;
  endtask

  // Leaves 5 words (0x44..0x48) stored with overflow already set.
  task automatic prepare_five_ovf();
    do_flush();
    for (int i = 0; i < 8; i++) push(8'h41 + 8'(i));
    push(8'h49);
    for (int i = 0; i < 3; i++) pop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    checks++; if (s_rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty got %b exp 1", s_rempty); end
    checks++; if (s_wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got %b exp 0", s_wfull); end
    checks++; if (s_fill !== 4'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", s_fill); end
    checks++; if (s_aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", s_aempty); end
    checks++; if (s_afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", s_afull); end
    checks++; if (s_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", s_rd_data); end
    checks++; if ({s_ovf, s_unf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {s_ovf, s_unf}); end
  endtask

  task automatic test_fill_drain_std();
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      checks++; if (s_fill !== 4'(i)) begin errors++; $display("FAIL fill_level_%0d got %0d exp %0d", i, s_fill, i); end
      checks++; if (s_afull !== (i >= 7)) begin errors++; $display("FAIL afull_at_%0d got %b exp %b", i, s_afull, (i >= 7)); end
      checks++; if (s_aempty !== (i <= 1)) begin errors++; $display("FAIL aempty_at_%0d got %b exp %b", i, s_aempty, (i <= 1)); end
      checks++; if (s_wfull !== (i == 8)) begin errors++; $display("FAIL wfull_at_%0d got %b exp %b", i, s_wfull, (i == 8)); end
    end
    checks++; if (f_rd_data !== 8'h01) begin errors++; $display("FAIL fwft_head got %h exp 01", f_rd_data); end
    push(8'd9);
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL overflow_set got %b exp 1", s_ovf); end
    checks++; if (s_fill !== 4'd8) begin errors++; $display("FAIL fill_after_ovf got %0d exp 8", s_fill); end
    for (int i = 1; i <= 8; i++) begin
      pop();
      checks++; if (s_rd_data !== 8'(i)) begin errors++; $display("FAIL read_%0d got %h exp %h", i, s_rd_data, 8'(i)); end
      checks++; if (s_fill !== 4'(8 - i)) begin errors++; $display("FAIL drain_fill_%0d got %0d exp %0d", i, s_fill, 8 - i); end
    end
    checks++; if (s_rempty !== 1'b1) begin errors++; $display("FAIL drained_rempty got %b exp 1", s_rempty); end
    checks++; if (s_unf !== 1'b0) begin errors++; $display("FAIL unf_early got %b exp 0", s_unf); end
    pop();
    checks++; if (s_unf !== 1'b1) begin errors++; $display("FAIL underflow_set got %b exp 1", s_unf); end
    checks++; if (s_rd_data !== 8'd8) begin errors++; $display("FAIL rd_hold got %h exp 08", s_rd_data); end
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", s_ovf); end
    do_flush();
  endtask

  task automatic test_fwft();
    push(8'hA5);
    checks++; if (f_rd_data !== 8'hA5) begin errors++; $display("FAIL fwft_show got %h exp a5", f_rd_data); end
    checks++; if (f_rempty !== 1'b0) begin errors++; $display("FAIL fwft_rempty got %b exp 0", f_rempty); end
    checks++; if (s_rd_data !== 8'h00) begin errors++; $display("FAIL std_no_show got %h exp 00", s_rd_data); end
    pop();
    checks++; if (f_rempty !== 1'b1) begin errors++; $display("FAIL fwft_popped got %b exp 1", f_rempty); end
    checks++; if (s_rd_data !== 8'hA5) begin errors++; $display("FAIL std_after_pop got %h exp a5", s_rd_data); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    int next_v = 1;
    int popped = 0;
    int c = 0;
    logic w, r;
    while (popped < 20 && c < 200) begin
      w = (next_v <= 20) && (exp_q.size() < 3) && (c % 4 != 3);
      r = (exp_q.size() > 0) && ((c % 3 != 0) || (next_v > 20));
      winc = w; rinc = r; wr_data = 8'(next_v);
      cycle();
      if (r) begin
        exp_v = exp_q.pop_front();
        popped++;
        checks++; if (s_rd_data !== exp_v) begin errors++; $display("FAIL wrap_read got %h exp %h", s_rd_data, exp_v); end
      end
      if (w) begin
        exp_q.push_back(8'(next_v));
        next_v++;
      end
      checks++; if (s_fill !== 4'(exp_q.size()) || s_fill > 4'd3) begin errors++; $display("FAIL wrap_fill got %0d exp %0d", s_fill, exp_q.size()); end
      c++;
    end
    winc = 1'b0; rinc = 1'b0;
    checks++; if (popped !== 20) begin errors++; $display("FAIL wrap_count got %0d exp 20", popped); end
  endtask

  task automatic test_simultaneous();
    do_flush();
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    winc = 1'b1; rinc = 1'b1; wr_data = 8'hEE;
    cycle();
    winc = 1'b0; rinc = 1'b0;
    checks++; if (s_fill !== 4'd7) begin errors++; $display("FAIL full_both_fill got %0d exp 7", s_fill); end
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL full_both_ovf got %b exp 1", s_ovf); end
    checks++; if (s_rd_data !== 8'h10) begin errors++; $display("FAIL full_both_data got %h exp 10", s_rd_data); end
    do_flush();
    winc = 1'b1; rinc = 1'b1; wr_data = 8'h33;
    cycle();
    winc = 1'b0; rinc = 1'b0;
    checks++; if (s_fill !== 4'd1) begin errors++; $display("FAIL empty_both_fill got %0d exp 1", s_fill); end
    checks++; if (s_unf !== 1'b1) begin errors++; $display("FAIL empty_both_unf got %b exp 1", s_unf); end
    checks++; if (s_rd_data !== 8'h00) begin errors++; $display("FAIL empty_both_data got %h exp 00", s_rd_data); end
    for (int i = 0; i < 3; i++) push(8'h34 + 8'(i));
    winc = 1'b1; rinc = 1'b1; wr_data = 8'h37;
    cycle();
    winc = 1'b0; rinc = 1'b0;
    checks++; if (s_fill !== 4'd4) begin errors++; $display("FAIL half_both_fill got %0d exp 4", s_fill); end
    checks++; if (s_rd_data !== 8'h33) begin errors++; $display("FAIL half_both_data got %h exp 33", s_rd_data); end
  endtask

  task automatic test_flush();
    prepare_five_ovf();
    checks++; if (s_fill !== 4'd5 || s_ovf !== 1'b1) begin errors++; $display("FAIL flush_pre got fill %0d ovf %b exp 5 1", s_fill, s_ovf); end
    flush = 1'b1; winc = 1'b1; wr_data = 8'h77;
    cycle();
    flush = 1'b0; winc = 1'b0;
    checks++; if (s_fill !== 4'd0) begin errors++; $display("FAIL flush_fill got %0d exp 0", s_fill); end
    checks++; if (s_rempty !== 1'b1) begin errors++; $display("FAIL flush_rempty got %b exp 1", s_rempty); end
    checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf got %b exp 0", s_ovf); end
    checks++; if (s_rd_data !== 8'h00) begin errors++; $display("FAIL flush_rd_data got %h exp 00", s_rd_data); end
    cycle();
    checks++; if (s_fill !== 4'd0) begin errors++; $display("FAIL flush_no_write got %0d exp 0", s_fill); end
    push(8'h55);
    pop();
    checks++; if (s_rd_data !== 8'h55) begin errors++; $display("FAIL post_flush_data got %h exp 55", s_rd_data); end
  endtask

  task automatic test_reset_mid_burst();
    prepare_five_ovf();
    push(8'h60);
    checks++; if (s_fill !== 4'd6) begin errors++; $display("FAIL burst_fill got %0d exp 6", s_fill); end
    winc = 1'b1; wr_data = 8'h61; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; winc = 1'b0;
    checks++; if (s_fill !== 4'd0) begin errors++; $display("FAIL rst_fill got %0d exp 0", s_fill); end
    checks++; if (s_rempty !== 1'b1) begin errors++; $display("FAIL rst_rempty got %b exp 1", s_rempty); end
    checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", s_ovf); end
    checks++; if (s_rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h exp 00", s_rd_data); end
    push(8'h62);
    pop();
    checks++; if (s_rd_data !== 8'h62) begin errors++; $display("FAIL post_rst_data got %h exp 62", s_rd_data); end
  endtask

  initial begin
    test_reset();
    test_fill_drain_std();
    test_fwft();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO for same-domain buffering inside the communication system, e.g. between the UART TX controller and the register file/ALU path. It is the single-domain counterpart of the dual-clock FIFO, generalised in depth and width and extended with:
- a first-word-fall-through (FWFT) mode,
- programmable almost-full/almost-empty thresholds,
- an occupancy count,
- sticky overflow/underflow flags and a synchronous flush.

## Interface
- data_width, 8: word width in bits.
- addr_size, 3: depth = 2**addr_size words.
- fwft, 0: 0 = standard registered read; 1 = first-word-fall-through.
- afull_thresh, 2**addr_size-1: wr_almost_full asserts when fill_level >= this.
- aempty_thresh, 1: rd_almost_empty asserts when fill_level <= this.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk.
- flush  in  1  synchronous clear of pointers, count and sticky flags.
- winc  in  1  write request.
- wr_data  in  data_width  write word.
- rinc  in  1  read/pop request.
- rd_data  out  data_width  read word.
- wfull  out  1  fill_level == depth.
- rempty  out  1  fill_level == 0.
- wr_almost_full  out  1  fill_level >= afull_thresh.
- rd_almost_empty  out  1  fill_level <= aempty_thresh.
- fill_level  out  addr_size+1  words held, 0..depth.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Pointers wptr/rptr are addr_size+1-bit binary and wrap naturally modulo 2*depth. The memory index is the low addr_size bits. fill_level is a separate registered counter.
- Write accepted iff winc && !wfull: mem[wptr] <= wr_data, wptr+1.
- Read accepted iff rinc && !rempty: rptr+1.
- Full with winc && rinc: the read is accepted, the write is rejected, and overflow sets.
- Empty with winc && rinc: the write is accepted, the read is rejected, and underflow sets.
- Both accepted in one cycle: fill_level unchanged.
- Standard mode (fwft=0): on an accepted read, rd_data <= mem[rptr] at the same edge. Otherwise rd_data holds its value.
- FWFT mode (fwft=1): rd_data = mem[rptr] combinationally; rinc pops the displayed word. rd_data is don't-care while rempty=1.
- overflow/underflow stay set until rst_n=0 or flush=1.
- flush=1: wptr=rptr=0, fill_level=0, overflow=underflow=0, rd_data=0 in standard mode. The memory array is untouched. flush overrides winc/rinc in the same cycle, and no flags set that cycle.
- Reset (rst_n=0) has the same effect as flush and overrides it. Reset values:
  - rd_data=0, wfull=0, rempty=1, fill_level=0, overflow=0, underflow=0.
  - wr_almost_full=(afull_thresh==0).
  - rd_almost_empty=1.
- The memory array is not reset.
- All status outputs decode from registered fill_level only; no combinational path from winc/rinc to any status output.

## Timing
- Write at edge N: rempty falls and fill_level updates immediately after edge N.
  - FWFT: the word is on rd_data after edge N.
  - Standard: the word appears on rd_data after the first accepted-read edge.
- Standard-mode read latency: 1 cycle (rinc sampled at edge M, data valid after M).
- Full→not-full and empty→not-empty transitions each take one edge, with no extra guard cycles.
- Drive inputs away from the rising edge (bench drives on the falling edge).

## Structure
- Shared package/header sync_fifo_defs holds:
  - default constants (data_width=8, addr_size=3);
  - fwft mode constants FIFO_STD=0 and FIFO_FWFT=1.
- Sub-module sync_fifo_mem:
  - depth×data_width register file;
  - synchronous write, asynchronous read port;
  - no reset.
- The top holds pointers, counter, flags and the fwft generate branch.

## Test plan
- Reset then idle, defaults: rempty=1, wfull=0, fill_level=0, rd_almost_empty=1, rd_data=0.
- Standard mode, write 1..8 on consecutive cycles:
  - wfull=1 and fill_level=8 after the 8th edge; wr_almost_full=1 from fill_level=7;
  - a 9th write (9) is rejected and sets overflow;
  - 8 reads return 1..8, each valid the cycle after rinc;
  - rempty=1 afterwards; a further rinc sets underflow.
- FWFT mode, write 0xA5: rd_data=0xA5 one edge later with no rinc; rinc pops it and rempty=1.
- Wrap-around: write/read 20 words (values 1..20) interleaved, keeping 0..3 stored; readout order 1..20 exact; fill_level never exceeds 3.
- Simultaneous events:
  - Full + winc + rinc: read accepted, write rejected, fill_level 8→7, overflow=1.
  - Empty + both: write accepted, fill_level 0→1, underflow=1.
  - Half-full + both: fill_level unchanged.
- Flush with 5 words stored plus overflow set, with winc=1 the same cycle: fill_level=0, rempty=1, overflow=0, no write. Repeat with rst_n=0 mid-burst: same result.
